// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: control-state encoding and the
// register-select codes that the controller hands to the datapath.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } gcd_state_e;

  typedef enum logic [1:0] {
    A_LOAD,
    A_SWAP,
    A_SUB,
    A_HOLD
  } a_sel_e;

  typedef enum logic [1:0] {
    B_LOAD,
    B_SWAP,
    B_HOLD
  } b_sel_e;

endpackage

// File: rtl/gcd_dp.sv
// GCD datapath: A/B operand registers with load/swap/subtract muxes and the
// two status flags the controller branches on.
//   clk_i, rst_ni  clock, async active-low reset (clears A and B)
//   a_sel, b_sel   register update selects from the controller
//   a_in, b_in     operands loaded on A_LOAD / B_LOAD
//   a_q, b_q       current register contents
//   b_zero         B == 0 (terminate condition)
//   a_lt_b         A < B (swap condition)
import gcd_pkg::*;

module gcd_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  a_sel_e           a_sel,
  input  b_sel_e           b_sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             b_zero,
  output logic             a_lt_b
);

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  always_comb begin
    a_d = a_q;
    case (a_sel)
      A_LOAD:  a_d = a_in;
      A_SWAP:  a_d = b_q;
      // Only selected when A >= B, so the difference never wraps.
      A_SUB:   a_d = a_q - b_q;
      default: a_d = a_q;
    endcase
  end

  always_comb begin
    b_d = b_q;
    case (b_sel)
      B_LOAD:  b_d = b_in;
      B_SWAP:  b_d = a_q;
      default: b_d = b_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign b_zero = (b_q == '0);
  assign a_lt_b = (a_q < b_q);

endmodule

// File: rtl/gcd_unit.sv
// Subtract-and-swap GCD engine with valid/ready request and response sides.
//   clk_i, rst_ni             clock, async active-low reset
//   req_valid_i/req_ready_o   operand handshake (accepted only in IDLE)
//   req_a_i, req_b_i          unsigned operands
//   resp_valid_o/resp_ready_i result handshake (result held until taken)
//   resp_gcd_o                gcd(A,B); shows live A outside DONE
//   resp_cycles_o             CALC cycles spent, saturating
//   busy_o                    high in CALC or DONE
//
// state | meaning
// IDLE  | waiting for an operand pair, req_ready_o high
// CALC  | one terminate/swap/subtract step per cycle, counting cycles
// DONE  | result presented until the consumer takes it
import gcd_pkg::*;

module gcd_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_gcd_o,
  output logic [CNT_W-1:0] resp_cycles_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  gcd_state_e       state_q;
  gcd_state_e       state_d;
  a_sel_e           a_sel;
  b_sel_e           b_sel;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             b_zero;
  logic             a_lt_b;
  logic             accept;

  gcd_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .a_sel  (a_sel),
    .b_sel  (b_sel),
    .a_in   (req_a_i),
    .b_in   (req_b_i),
    .a_q    (a_q),
    .b_q    (b_q),
    .b_zero (b_zero),
    .a_lt_b (a_lt_b)
  );

  assign accept = (state_q == IDLE) && req_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sel   = A_HOLD;
    b_sel   = B_HOLD;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          a_sel   = A_LOAD;
          b_sel   = B_LOAD;
          state_d = CALC;
        end
      end
      CALC: begin
        if (b_zero) begin
          state_d = DONE;
        end else if (a_lt_b) begin
          a_sel = A_SWAP;
          b_sel = B_SWAP;
        end else begin
          a_sel = A_SUB;
        end
      end
      DONE: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every CALC cycle counts, including the terminating one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == CALC) && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign resp_valid_o  = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);
  assign resp_gcd_o    = a_q;
  assign resp_cycles_o = cnt_q;

endmodule
